// File: rtl/rsa_stream_loader.sv
// rtl/rsa_stream_loader.sv - byte-stream operand loader and result unloader for an RSA exponentiation core
// Optional core watchdog enabled by defining LOADER_TIMEOUT_EN.

module rsa_stream_loader #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [7:0]   out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [255:0] core_N_o,
  output logic [255:0] core_d_o,
  output logic [255:0] core_M_o,
  output logic         core_start_o,
  input  logic         core_ready_i,
  input  logic [255:0] core_S_i,
  output logic         busy_o,
  output logic         err_o
);

  localparam logic [3:0] S_LOAD_N    = 4'd0;
  localparam logic [3:0] S_LOAD_D    = 4'd1;
  localparam logic [3:0] S_LOAD_M    = 4'd2;
  localparam logic [3:0] S_START     = 4'd3;
  localparam logic [3:0] S_WAIT_BUSY = 4'd4;
  localparam logic [3:0] S_WAIT_DONE = 4'd5;
  localparam logic [3:0] S_CAPTURE   = 4'd6;
  localparam logic [3:0] S_SEND      = 4'd7;
`ifdef LOADER_TIMEOUT_EN
  localparam logic [3:0] S_ERR       = 4'd8;
`endif

  logic [3:0]   r_state;
  logic [4:0]   r_cnt;
  logic [255:0] r_n;
  logic [255:0] r_d;
  logic [255:0] r_m;
  logic [255:0] r_shift;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_last_byte;

  assign in_ready_o   = (r_state == S_LOAD_N) || (r_state == S_LOAD_D) || (r_state == S_LOAD_M);
  assign out_valid_o  = (r_state == S_SEND);
  assign out_data_o   = r_shift[255:248];
  assign core_start_o = (r_state == S_START);
  assign busy_o       = !((r_state == S_LOAD_N) && (r_cnt == 5'd0));
  assign core_N_o     = r_n;
  assign core_d_o     = r_d;
  assign core_M_o     = r_m;

  assign w_in_fire   = in_valid_i && in_ready_o;
  assign w_out_fire  = out_valid_o && out_ready_i;
  assign w_last_byte = (r_cnt == 5'd31);

`ifdef LOADER_TIMEOUT_EN
  logic [23:0] r_to;
  logic        w_to_hit;

  assign w_to_hit = ((r_to + 24'd1) == TIMEOUT_CYCLES);
  assign err_o    = (r_state == S_ERR);

  // Cleared in START so the count starts fresh on entry to WAIT_BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to <= 24'd0;
    end else if (r_state == S_START) begin
      r_to <= 24'd0;
    end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) begin
      r_to <= r_to + 24'd1;
    end
  end
`else
  logic w_timeout_unused;
  assign w_timeout_unused = ^TIMEOUT_CYCLES;
  assign err_o            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD_N;
      r_cnt   <= 5'd0;
      r_n     <= '0;
      r_d     <= '0;
      r_m     <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_LOAD_N: if (w_in_fire) begin
          r_n   <= {r_n[247:0], in_data_i};
          r_cnt <= r_cnt + 5'd1;
          if (w_last_byte) r_state <= S_LOAD_D;
        end
        S_LOAD_D: if (w_in_fire) begin
          r_d   <= {r_d[247:0], in_data_i};
          r_cnt <= r_cnt + 5'd1;
          if (w_last_byte) r_state <= S_LOAD_M;
        end
        S_LOAD_M: if (w_in_fire) begin
          r_m   <= {r_m[247:0], in_data_i};
          r_cnt <= r_cnt + 5'd1;
          if (w_last_byte) r_state <= S_START;
        end
        S_START: r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (!core_ready_i) r_state <= S_WAIT_DONE;
`ifdef LOADER_TIMEOUT_EN
          if (w_to_hit) r_state <= S_ERR;
`endif
        end
        S_WAIT_DONE: begin
          if (core_ready_i) r_state <= S_CAPTURE;
`ifdef LOADER_TIMEOUT_EN
          if (w_to_hit) r_state <= S_ERR;
`endif
        end
        // The core updates its result one edge after ready rises, so sample it here.
        S_CAPTURE: begin
          r_shift <= core_S_i;
          r_state <= S_SEND;
        end
        S_SEND: if (w_out_fire) begin
          r_shift <= {r_shift[247:0], 8'h00};
          r_cnt   <= r_cnt + 5'd1;
          if (w_last_byte) r_state <= S_LOAD_N;
        end
`ifdef LOADER_TIMEOUT_EN
        S_ERR: r_state <= S_ERR;
`endif
        default: r_state <= S_LOAD_N;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_stream_loader.sv
// tb/tb_rsa_stream_loader.sv - self-checking bench for rsa_stream_loader with a behavioural core
// Build with LOADER_TIMEOUT_EN defined to exercise the watchdog path.

module tb_rsa_stream_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready_o;
  logic [7:0]   out_data_o;
  logic         out_valid_o;
  logic         out_ready;
  logic [255:0] core_N_o, core_d_o, core_M_o;
  logic         core_start_o;
  logic         core_ready = 1'b1;
  logic [255:0] core_S = '0;
  logic         busy_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  rsa_stream_loader #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset(reset),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .core_N_o(core_N_o), .core_d_o(core_d_o), .core_M_o(core_M_o),
    .core_start_o(core_start_o), .core_ready_i(core_ready), .core_S_i(core_S),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] modexp(input logic [255:0] m, input logic [255:0] d,
                                          input logic [255:0] n);
    logic [63:0] r, b, nn;
    nn = n[63:0];
    r  = 64'd1 % nn;
    b  = m[63:0] % nn;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return {192'd0, r};
  endfunction

  // Behavioural core: ready drops after start, rises after a few cycles, result one edge later.
  logic         core_hold = 1'b0;
  int           core_lat = 0;
  logic         core_rise = 1'b0;
  logic [255:0] core_res = '0;
  always @(posedge clk) begin
    if (reset) begin
      core_ready <= 1'b1;
      core_lat   <= 0;
      core_rise  <= 1'b0;
    end else begin
      core_rise <= 1'b0;
      if (core_start_o) begin
        core_ready <= 1'b0;
        core_lat   <= 3;
        core_res   <= modexp(core_M_o, core_d_o, core_N_o);
      end else if (!core_ready && !core_hold) begin
        if (core_lat == 0) begin
          core_ready <= 1'b1;
          core_rise  <= 1'b1;
        end else begin
          core_lat <= core_lat - 1;
        end
      end
      if (core_rise) core_S <= core_res;
    end
  end

  // Model: rebuild operands from accepted bytes, predict result bytes, check on every cycle.
  logic [7:0]   op_bytes [96];
  int           acc_cnt = 0;
  int           starts = 0;
  logic [7:0]   exp_q [$];
  logic [7:0]   rx_log [$];
  logic [255:0] mod_n, mod_d, mod_m;
  logic         prev_start = 1'b0;
  logic         stall_prev = 1'b0;
  logic [7:0]   held = 8'h00;
  logic         last_pending = 1'b0;

  always @(negedge clk) begin
    if (last_pending) begin
      check("in_ready_after_last", in_ready_o, 1);
      last_pending = 1'b0;
    end
    if (reset) begin
      acc_cnt = 0;
      exp_q.delete();
      stall_prev = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (stall_prev && out_valid_o) check("stall_hold", out_data_o, held);
      stall_prev = out_valid_o && !out_ready;
      if (stall_prev) held = out_data_o;
      if (in_valid && in_ready_o) begin
        if (acc_cnt < 96) op_bytes[acc_cnt] = in_data;
        acc_cnt++;
      end
      if (core_start_o) begin
        check("start_width", prev_start, 0);
        check("start_after_96", acc_cnt, 96);
        mod_n = '0; mod_d = '0; mod_m = '0;
        for (int i = 0; i < 32; i++) begin
          mod_n = {mod_n[247:0], op_bytes[i]};
          mod_d = {mod_d[247:0], op_bytes[32+i]};
          mod_m = {mod_m[247:0], op_bytes[64+i]};
        end
        check("core_N", core_N_o, mod_n);
        check("core_d", core_d_o, mod_d);
        check("core_M", core_M_o, mod_m);
        begin
          logic [255:0] r;
          r = modexp(mod_m, mod_d, mod_n);
          for (int i = 0; i < 32; i++) exp_q.push_back(r[255-8*i -: 8]);
        end
        starts++;
        acc_cnt = 0;
      end
      prev_start = core_start_o;
      if (out_valid_o && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("out_byte", out_data_o, exp_q.pop_front());
          check("hold_M", core_M_o, mod_m);
          if (exp_q.size() == 0) begin
            check("in_ready_during_last", in_ready_o, 0);
            last_pending = 1'b1;
          end
        end
        rx_log.push_back(out_data_o);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_o && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("send_wait", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_ops(input logic [255:0] n, input logic [255:0] d, input logic [255:0] m,
                          input bit gaps);
    logic [255:0] v;
    for (int k = 0; k < 3; k++) begin
      v = (k == 0) ? n : (k == 1) ? d : m;
      for (int i = 0; i < 32; i++) begin
        send_byte(v[255-8*i -: 8]);
        if (gaps && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_at);
    int base = rx_log.size();
    int guard = 0;
    bit stalled = 0;
    while (rx_log.size() < base + n && guard < 3000) begin
      if (stall_at >= 0 && !stalled && rx_log.size() - base == stall_at) begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        stalled = 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    check("collect_done", rx_log.size() >= base + n, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 8'h00);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_start", core_start_o, 0);
    check("rst_N", core_N_o, 0);
    check("rst_d", core_d_o, 0);
    check("rst_M", core_M_o, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, st0, guard;
    logic [255:0] v;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals();

    // Basic operation, in_valid held high.
    base = rx_log.size();
    send_ops(256'd13, 256'd5, 256'd2, 0);
    collect(32, -1);
    check("op1_starts", starts, 1);
    check("op1_first", rx_log[base], 8'h00);
    check("op1_last", rx_log[base+31], 8'h06);

    // Random input gaps and a 5-cycle sink stall mid-SEND.
    base = rx_log.size();
    send_ops(256'd13, 256'd5, 256'd2, 1);
    collect(32, 10);
    check("op2_starts", starts, 2);
    check("op2_last", rx_log[base+31], 8'h06);

    // Reset at load byte 40, then full reload.
    for (int i = 0; i < 40; i++) begin
      v = (i < 32) ? 256'd13 : 256'd5;
      send_byte(v[255-8*(i%32) -: 8]);
    end
    check("midload_busy", busy_o, 1);
    do_reset();
    check_reset_vals();
    st0 = starts;
    base = rx_log.size();
    send_ops(256'd13, 256'd5, 256'd2, 0);
    collect(32, -1);
    check("op3_starts", starts, st0 + 1);
    check("op3_last", rx_log[base+31], 8'h06);

    // Back-to-back: M=2 then M=3 overlapping send with collect.
    base = rx_log.size();
    send_ops(256'd13, 256'd5, 256'd2, 0);
    fork
      collect(32, -1);
      send_ops(256'd13, 256'd5, 256'd3, 0);
    join
    collect(32, -1);
    check("b2b_first_last", rx_log[base+31], 8'h06);
    check("b2b_second_last", rx_log[base+63], 8'h09);

    // Core never completes.
    core_hold = 1'b1;
    st0 = starts;
    send_ops(256'd13, 256'd5, 256'd2, 0);
    guard = 0;
    while (!core_start_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("hang_start_seen", core_start_o, 1);
    @(posedge clk);
`ifdef LOADER_TIMEOUT_EN
    repeat (99) @(posedge clk);
    #1;
    check("to_err_before", err_o, 0);
    @(posedge clk); #1;
    check("to_err", err_o, 1);
    check("to_in_ready", in_ready_o, 0);
    check("to_out_valid", out_valid_o, 0);
    repeat (20) @(posedge clk);
    #1;
    check("to_err_sticky", err_o, 1);
`else
    repeat (1000) @(posedge clk);
    #1;
    check("hang_err", err_o, 0);
    check("hang_in_ready", in_ready_o, 0);
    check("hang_out_valid", out_valid_o, 0);
    check("hang_busy", busy_o, 1);
    check("hang_starts", starts, st0 + 1);
`endif
    core_hold = 1'b0;
    do_reset();
    check_reset_vals();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_stream_loader.md
RSA_STREAM_LOADER -- requirements
Module: rsa_stream_loader

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 24'd1000000, the core watchdog limit in clk cycles.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  clk  input  1  single clock, rising edge.
  reset  input  1  synchronous, active-high.
  in_data_i  input  8  operand byte stream.
  in_valid_i  input  1  in_data_i valid.
  in_ready_o  output  1  loader accepts a byte.
  out_data_o  output  8  result byte stream.
  out_valid_o  output  1  out_data_o valid.
  out_ready_i  input  1  sink accepts a byte.
  core_N_o  output  256  modulus to the exponentiation core.
  core_d_o  output  256  exponent to the core.
  core_M_o  output  256  message to the core.
  core_start_o  output  1  one-cycle start pulse to the core.
  core_ready_i  input  1  core idle/done; low while computing.
  core_S_i  input  256  core result register.
  busy_o  output  1  high in every state except LOAD_N with byte count 0.
  err_o  output  1  sticky core-timeout flag.

Function
REQ-003 A byte SHALL transfer only on a rising edge where in_valid_i and in_ready_o are both high; out bytes SHALL transfer likewise on out_valid_o and out_ready_i.
REQ-004 The FSM states SHALL be LOAD_N, LOAD_D, LOAD_M, START, WAIT_BUSY, WAIT_DONE, CAPTURE, SEND and ERR.
REQ-005 in_ready_o SHALL be high only in LOAD_N, LOAD_D and LOAD_M.
REQ-006 Each operand SHALL arrive as 32 bytes, MSB byte first; each accepted byte SHALL shift the target register left by 8 with the byte entering bits [7:0].
REQ-007 A 5-bit byte counter SHALL increment per accepted byte.
REQ-008 On the transfer at count 31, the counter SHALL wrap to 0 and the state SHALL advance LOAD_N->LOAD_D->LOAD_M->START.
REQ-009 No byte SHALL be lost or duplicated when in_valid_i is held high continuously.
REQ-010 In START, core_start_o SHALL be high for exactly one cycle and the state SHALL advance to WAIT_BUSY; core_start_o SHALL be low in every other state.
REQ-011 core_N_o, core_d_o and core_M_o SHALL be register outputs and SHALL hold constant from START until the next LOAD_N byte transfer.
REQ-012 WAIT_BUSY SHALL advance to WAIT_DONE on the first cycle core_ready_i is sampled low.
REQ-013 WAIT_DONE SHALL advance to CAPTURE on the first cycle core_ready_i is sampled high.
REQ-014 CAPTURE SHALL last one cycle and load core_S_i into a 256-bit output shift register; this one-cycle delay exists because the core registers its result one edge after ready rises.
REQ-015 In SEND, out_valid_o SHALL be 1 and out_data_o SHALL equal shift register bits [255:248].
REQ-016 In SEND, each out transfer SHALL shift the register left by 8 and increment the byte counter.
REQ-017 In SEND, out_data_o SHALL remain stable while out_valid_o is high and out_ready_i is low.
REQ-018 The 32nd out transfer SHALL return the FSM to LOAD_N with the counter at 0.
REQ-019 out_valid_o SHALL be low outside SEND.
REQ-020 Back-to-back operation SHALL be supported: a new operand load SHALL begin in the cycle after the last result byte transfers.

Reset
REQ-021 A reset sampled high SHALL, on that edge and regardless of state (including mid-load, mid-compute or mid-send), force: state LOAD_N, byte counter 0, all operand and shift registers 0, core_start_o 0, in_ready_o 1, out_valid_o 0, out_data_o 8'h00, err_o 0 and busy_o 0.
REQ-022 A reset during WAIT_DONE SHALL NOT issue core_start_o; the core result SHALL then be ignored.

Configuration
REQ-023 The macro LOADER_TIMEOUT_EN SHALL control the core watchdog.
REQ-024 With LOADER_TIMEOUT_EN defined, a 24-bit counter SHALL clear on entry to WAIT_BUSY and increment each cycle in WAIT_BUSY and WAIT_DONE.
REQ-025 With LOADER_TIMEOUT_EN defined, when that counter reaches TIMEOUT_CYCLES the FSM SHALL enter ERR.
REQ-026 In ERR, err_o SHALL be 1, in_ready_o and out_valid_o SHALL be 0, and the state SHALL be left only by reset.
REQ-027 With LOADER_TIMEOUT_EN undefined, the counter and ERR state SHALL NOT exist, err_o SHALL be constant 0, and WAIT_BUSY/WAIT_DONE SHALL wait indefinitely.

Verification
REQ-028 Load with N=13, d=5, M=2 (each 31 zero bytes followed by the value byte) and a behavioural core -> exactly one core_start_o pulse, then result bytes 31x 8'h00 followed by 8'h06.
REQ-029 Apply in_valid_i with random gaps and out_ready_i low for 5 cycles mid-SEND -> same 32 result bytes, and out_data_o held throughout the stall.
REQ-030 Assert reset at load byte 40 (within LOAD_D), then run a full new load -> outputs at reset values on the next cycle, core_start_o only after the 96th new byte.
REQ-031 Run two back-to-back operations (M=2, then M=3, same N and d) -> results 6 then 9; in_ready_o rises the cycle after the 32nd out byte.
REQ-032 With LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=100 and core_ready_i held low -> err_o=1 and in_ready_o=0 at cycle 100 after entering WAIT_BUSY; without the macro, the block is still in WAIT_DONE at cycle 1000.
